mc_config_loader: RTL and testbench

MC_CONFIG_LOADER -- requirements
Module: mc_config_loader

---
 rtl/mc_config_loader_pkg.sv | 42 ++++
 rtl/mc_config_loader_shifter.sv | 75 +++++++
 rtl/mc_config_loader.sv | 191 +++++++++++++++++++
 tb/tb_mc_config_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_config_loader_pkg.sv
// Shared definitions for the configuration loader: the FSM state encoding,
// the fixed frame width, counter limits, and the frame bit index of every
// configuration field, listed in serial order (first received = index 0).
package mc_config_loader_pkg;

  localparam int unsigned CFG_W_C = 20;

  // The bit counter is 5 bits wide and saturates at CNT_MAX.
  localparam logic [4:0] CNT_MAX  = 5'd20;
  localparam logic [4:0] LAST_BIT = 5'd19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_COMMIT,
    ST_READ,
    ST_ERROR
  } state_e;

  localparam int unsigned IDX_PT1      = 0;
  localparam int unsigned IDX_PT2      = 1;
  localparam int unsigned IDX_PT3      = 2;
  localparam int unsigned IDX_PT4      = 3;
  localparam int unsigned IDX_PT5      = 4;
  localparam int unsigned IDX_GCLR     = 5;
  localparam int unsigned IDX_PT4_FUNC = 6;
  localparam int unsigned IDX_PT5_FUNC = 7;
  localparam int unsigned IDX_XOR_A    = 8;
  localparam int unsigned IDX_XOR_B    = 9;
  localparam int unsigned IDX_XOR_INV  = 10;
  localparam int unsigned IDX_D        = 11;
  localparam int unsigned IDX_STORAGE  = 12;
  localparam int unsigned IDX_FB       = 13;
  localparam int unsigned IDX_O        = 14;
  localparam int unsigned IDX_OE0      = 15;
  localparam int unsigned IDX_OE1      = 16;
  localparam int unsigned IDX_OE2      = 17;
  localparam int unsigned IDX_GCLK0    = 18;
  localparam int unsigned IDX_GCLK1    = 19;

endpackage

// File: rtl/mc_config_loader_shifter.sv
// mc_cfg_shifter: bit counter, shadow register and running parity for the
// configuration loader.
//   clk, rst     : clock, asynchronous active-high reset
//   clr          : zero counter, shadow and parity (start of a frame/readback)
//   wr_en        : write bit_in into shadow[cnt], advance counter, fold parity
//   rd_step      : advance counter, fold the presented readback bit into parity
//   bit_in       : serial write data
//   rd_cfg       : active configuration presented during readback
//   cnt          : current bit counter (saturates at 20)
//   shadow_nxt   : shadow contents including any bit written this cycle
//   par          : running XOR of accepted / presented bits
//   rd_bit       : rd_cfg[cnt] for cnt<20, else the running parity
module mc_cfg_shifter
  import mc_config_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic               rd_step,
  input  logic               bit_in,
  input  logic [CFG_W_C-1:0] rd_cfg,
  output logic [4:0]         cnt,
  output logic [CFG_W_C-1:0] shadow_nxt,
  output logic               par,
  output logic               rd_bit
);

  logic [4:0]         cnt_q, cnt_d;
  logic [CFG_W_C-1:0] shadow_q, shadow_d;
  logic               par_q, par_d;

  // Once all data bits have been presented, the running parity is exactly the
  // bit that makes the readback total even.
  assign rd_bit = (cnt_q < CNT_MAX) ? rd_cfg[cnt_q] : par_q;

  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    par_d    = par_q;
    if (clr) begin
      cnt_d    = '0;
      shadow_d = '0;
      par_d    = 1'b0;
    end else if (wr_en) begin
      if (cnt_q < CNT_MAX) begin
        shadow_d[cnt_q] = bit_in;
        cnt_d           = cnt_q + 5'd1;
      end
      par_d = par_q ^ bit_in;
    end else if (rd_step) begin
      if (cnt_q < CNT_MAX) begin
        cnt_d = cnt_q + 5'd1;
      end
      par_d = par_q ^ rd_bit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      par_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      par_q    <= par_d;
    end
  end

  assign cnt        = cnt_q;
  assign shadow_nxt = shadow_d;
  assign par        = par_q;

endmodule

// File: rtl/mc_config_loader.sv
// mc_config_loader: serial loader and readback port for one macrocell's
// configuration. A write frame is 20 data bits (plus an even-parity bit when
// PARITY_EN=1); a successful frame is committed atomically to the active
// configuration outputs. A readback frame shifts the active configuration out
// on tdo_v, followed by its parity bit when PARITY_EN=1.
//   clk_v, rst_v              : clock, asynchronous active-high reset
//   ld_start_v / rd_start_v   : start write / readback frame (ld wins)
//   bit_v, bit_valid_v        : serial write data and qualifier
//   tdo_v, tdo_valid_v        : serial readback data and qualifier
//   busy_v, done_v, err_v     : not-idle, completion pulse, sticky error
//   *_mux, oe_mux, gclk_mux   : active configuration to the cellcore muxes
module mc_config_loader
  import mc_config_loader_pkg::*;
#(
  parameter  bit          PARITY_EN = 1'b1,
  localparam int unsigned CFG_W     = CFG_W_C
) (
  input  logic       clk_v,
  input  logic       rst_v,
  input  logic       ld_start_v,
  input  logic       rd_start_v,
  input  logic       bit_v,
  input  logic       bit_valid_v,
  output logic       tdo_v,
  output logic       tdo_valid_v,
  output logic       busy_v,
  output logic       done_v,
  output logic       err_v,
  output logic       pt1_mux,
  output logic       pt2_mux,
  output logic       pt3_mux,
  output logic       pt4_mux,
  output logic       pt5_mux,
  output logic       gclr_mux,
  output logic       pt4_func_mux,
  output logic       pt5_func_mux,
  output logic       xor_a_mux,
  output logic       xor_b_mux,
  output logic       xor_inv_mux,
  output logic       d_mux,
  output logic       storage_mux,
  output logic       fb_mux,
  output logic       o_mux,
  output logic [0:2] oe_mux,
  output logic [0:1] gclk_mux
);

  state_e             state_q, state_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic [CFG_W-1:0]   active_q, active_d;

  logic               sh_clr, sh_wr, sh_rd, commit_load;
  logic [4:0]         sh_cnt;
  logic [CFG_W-1:0]   sh_nxt;
  logic               sh_par, sh_rd_bit;
  logic [4:0]         rd_last;

  assign rd_last = PARITY_EN ? CNT_MAX : LAST_BIT;

  mc_cfg_shifter u_shifter (
    .clk        (clk_v),
    .rst        (rst_v),
    .clr        (sh_clr),
    .wr_en      (sh_wr),
    .rd_step    (sh_rd),
    .bit_in     (bit_v),
    .rd_cfg     (active_q),
    .cnt        (sh_cnt),
    .shadow_nxt (sh_nxt),
    .par        (sh_par),
    .rd_bit     (sh_rd_bit)
  );

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    done_d      = 1'b0;
    sh_clr      = 1'b0;
    sh_wr       = 1'b0;
    sh_rd       = 1'b0;
    commit_load = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ld_start_v) begin
          sh_clr  = 1'b1;
          state_d = ST_SHIFT;
        end else if (rd_start_v) begin
          sh_clr  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_SHIFT: begin
        if (ld_start_v) begin
          sh_clr  = 1'b1;
        end else if (bit_valid_v) begin
          sh_wr = 1'b1;
          if (sh_cnt == LAST_BIT) begin
            if (PARITY_EN) begin
              state_d = ST_PARITY;
            end else begin
              commit_load = 1'b1;
              state_d     = ST_COMMIT;
            end
          end
        end
      end
      ST_PARITY: begin
        if (ld_start_v) begin
          sh_clr  = 1'b1;
          state_d = ST_SHIFT;
        end else if (bit_valid_v) begin
          if ((sh_par ^ bit_v) == 1'b0) begin
            commit_load = 1'b1;
            state_d     = ST_COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      ST_READ: begin
        sh_rd = 1'b1;
        if (sh_cnt == rd_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (ld_start_v) begin
          sh_clr  = 1'b1;
          err_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The active register loads on the edge that accepts the final frame bit,
    // so outputs change on the same edge that raises done_v; the COMMIT state
    // then only holds the one-cycle done pulse.
    if (commit_load) begin
      done_d = 1'b1;
    end
    active_d = commit_load ? sh_nxt : active_q;
  end

  always_ff @(posedge clk_v or posedge rst_v) begin
    if (rst_v) begin
      state_q  <= ST_IDLE;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      active_q <= '0;
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
      done_q   <= done_d;
      active_q <= active_d;
    end
  end

  assign busy_v      = (state_q != ST_IDLE);
  assign done_v      = done_q;
  assign err_v       = err_q;
  assign tdo_valid_v = (state_q == ST_READ);
  assign tdo_v       = (state_q == ST_READ) ? sh_rd_bit : 1'b0;

  assign pt1_mux      = active_q[IDX_PT1];
  assign pt2_mux      = active_q[IDX_PT2];
  assign pt3_mux      = active_q[IDX_PT3];
  assign pt4_mux      = active_q[IDX_PT4];
  assign pt5_mux      = active_q[IDX_PT5];
  assign gclr_mux     = active_q[IDX_GCLR];
  assign pt4_func_mux = active_q[IDX_PT4_FUNC];
  assign pt5_func_mux = active_q[IDX_PT5_FUNC];
  assign xor_a_mux    = active_q[IDX_XOR_A];
  assign xor_b_mux    = active_q[IDX_XOR_B];
  assign xor_inv_mux  = active_q[IDX_XOR_INV];
  assign d_mux        = active_q[IDX_D];
  assign storage_mux  = active_q[IDX_STORAGE];
  assign fb_mux       = active_q[IDX_FB];
  assign o_mux        = active_q[IDX_O];
  assign oe_mux[0]    = active_q[IDX_OE0];
  assign oe_mux[1]    = active_q[IDX_OE1];
  assign oe_mux[2]    = active_q[IDX_OE2];
  assign gclk_mux[0]  = active_q[IDX_GCLK0];
  assign gclk_mux[1]  = active_q[IDX_GCLK1];

endmodule

// File: tb/tb_mc_config_loader.sv
// Directed bench for mc_config_loader: table of write frames with expected
// results, plus hand-written readback, restart and mid-frame reset sequences.
module tb_mc_config_loader;

  logic       clk_v = 1'b0;
  logic       rst_v, ld_start_v, rd_start_v, bit_v, bit_valid_v;
  logic       tdo_v, tdo_valid_v, busy_v, done_v, err_v;
  logic       pt1_mux, pt2_mux, pt3_mux, pt4_mux, pt5_mux, gclr_mux;
  logic       pt4_func_mux, pt5_func_mux, xor_a_mux, xor_b_mux, xor_inv_mux;
  logic       d_mux, storage_mux, fb_mux, o_mux;
  logic [0:2] oe_mux;
  logic [0:1] gclk_mux;

  int n_checks = 0;
  int n_fail   = 0;

  mc_config_loader #(.PARITY_EN(1'b1)) dut (
    .clk_v        (clk_v),
    .rst_v        (rst_v),
    .ld_start_v   (ld_start_v),
    .rd_start_v   (rd_start_v),
    .bit_v        (bit_v),
    .bit_valid_v  (bit_valid_v),
    .tdo_v        (tdo_v),
    .tdo_valid_v  (tdo_valid_v),
    .busy_v       (busy_v),
    .done_v       (done_v),
    .err_v        (err_v),
    .pt1_mux      (pt1_mux),
    .pt2_mux      (pt2_mux),
    .pt3_mux      (pt3_mux),
    .pt4_mux      (pt4_mux),
    .pt5_mux      (pt5_mux),
    .gclr_mux     (gclr_mux),
    .pt4_func_mux (pt4_func_mux),
    .pt5_func_mux (pt5_func_mux),
    .xor_a_mux    (xor_a_mux),
    .xor_b_mux    (xor_b_mux),
    .xor_inv_mux  (xor_inv_mux),
    .d_mux        (d_mux),
    .storage_mux  (storage_mux),
    .fb_mux       (fb_mux),
    .o_mux        (o_mux),
    .oe_mux       (oe_mux),
    .gclk_mux     (gclk_mux)
  );

  always #5 clk_v = ~clk_v;

  typedef struct {
    logic [19:0] data;
    logic        par;
    bit          gap;
    logic        exp_done;
    logic        exp_err;
    logic [19:0] exp_cfg;
  } vec_t;

  vec_t vecs[6];

  // Gather the config outputs back into frame order (index 0 = pt1).
  function automatic logic [19:0] cfg_now();
    logic [19:0] v;
    v = {gclk_mux[1], gclk_mux[0], oe_mux[2], oe_mux[1], oe_mux[0], o_mux,
         fb_mux, storage_mux, d_mux, xor_inv_mux, xor_b_mux, xor_a_mux,
         pt5_func_mux, pt4_func_mux, gclr_mux, pt5_mux, pt4_mux, pt3_mux,
         pt2_mux, pt1_mux};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_v);
    #1;
  endtask

  // Start a frame, send nbits data bits (optionally spaced by idle cycles),
  // then the parity bit if with_par. Returns 1 time unit after the edge that
  // accepted the last bit.
  task automatic send_frame(input logic [19:0] data, input logic par, input bit gap,
                            input int nbits, input bit with_par);
    ld_start_v = 1'b1;
    tick();
    ld_start_v = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (gap) begin
        bit_valid_v = 1'b0;
        bit_v       = 1'b1;
        tick();
        check("busy_during_gap", busy_v, 1'b1);
      end
      bit_valid_v = 1'b1;
      bit_v       = data[i];
      tick();
    end
    if (with_par) begin
      if (gap) begin
        bit_valid_v = 1'b0;
        tick();
        check("busy_during_gap", busy_v, 1'b1);
      end
      bit_valid_v = 1'b1;
      bit_v       = par;
      tick();
    end
    bit_valid_v = 1'b0;
    bit_v       = 1'b0;
  endtask

  task automatic commit_ok(input string name, input logic [19:0] data, input logic par);
    send_frame(data, par, 1'b0, 20, 1'b1);
    check({name, "_done"}, done_v, 1'b1);
    check({name, "_cfg"}, cfg_now(), data);
    check({name, "_err"}, err_v, 1'b0);
    tick();
    check({name, "_done_clear"}, done_v, 1'b0);
  endtask

  // Readback: expects 20 data bits then the parity bit, then a done pulse.
  // With poke set, ld_start_v and bit_valid_v are driven mid-readback.
  task automatic read_check(input logic [19:0] data, input logic par, input bit poke);
    logic exp_bit;
    rd_start_v = 1'b1;
    tick();
    rd_start_v = 1'b0;
    for (int i = 0; i < 21; i++) begin
      exp_bit = (i < 20) ? data[i] : par;
      check("rd_tdo_valid", tdo_valid_v, 1'b1);
      check($sformatf("rd_tdo_bit%0d", i), tdo_v, exp_bit);
      check("rd_no_done", done_v, 1'b0);
      if (poke && i == 5) begin
        ld_start_v  = 1'b1;
        bit_valid_v = 1'b1;
        bit_v       = 1'b1;
      end
      tick();
      ld_start_v  = 1'b0;
      bit_valid_v = 1'b0;
      bit_v       = 1'b0;
    end
    check("rd_done", done_v, 1'b1);
    check("rd_tdo_valid_end", tdo_valid_v, 1'b0);
    check("rd_busy_end", busy_v, 1'b0);
    check("rd_cfg_kept", cfg_now(), data);
    tick();
    check("rd_done_clear", done_v, 1'b0);
  endtask

  initial begin
    //          data      par   gap   done  err   cfg
    vecs[0] = '{20'h4C005, 1'b1, 1'b0, 1'b1, 1'b0, 20'h4C005};
    vecs[1] = '{20'h0000F, 1'b1, 1'b0, 1'b0, 1'b1, 20'h4C005};
    vecs[2] = '{20'h4C005, 1'b0, 1'b0, 1'b0, 1'b1, 20'h4C005};
    vecs[3] = '{20'h12345, 1'b1, 1'b1, 1'b1, 1'b0, 20'h12345};
    vecs[4] = '{20'h4C005, 1'b1, 1'b1, 1'b1, 1'b0, 20'h4C005};
    vecs[5] = '{20'hFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 20'hFFFFF};

    rst_v       = 1'b1;
    ld_start_v  = 1'b0;
    rd_start_v  = 1'b0;
    bit_v       = 1'b0;
    bit_valid_v = 1'b0;
    tick();
    tick();
    check("reset_cfg", cfg_now(), 20'h0);
    check("reset_busy", busy_v, 1'b0);
    check("reset_done", done_v, 1'b0);
    check("reset_err", err_v, 1'b0);
    check("reset_tdo_valid", tdo_valid_v, 1'b0);
    check("reset_tdo", tdo_v, 1'b0);
    rst_v = 1'b0;
    tick();

    // Named-field spot checks for the first frame.
    send_frame(20'h4C005, 1'b1, 1'b0, 20, 1'b1);
    check("f1_done", done_v, 1'b1);
    check("f1_pt1", pt1_mux, 1'b1);
    check("f1_pt2", pt2_mux, 1'b0);
    check("f1_pt3", pt3_mux, 1'b1);
    check("f1_o", o_mux, 1'b1);
    check("f1_oe", oe_mux, 3'b100);
    check("f1_gclk", gclk_mux, 2'b10);
    check("f1_err", err_v, 1'b0);
    tick();
    check("f1_idle", busy_v, 1'b0);

    for (int k = 0; k < 6; k++) begin
      send_frame(vecs[k].data, vecs[k].par, vecs[k].gap, 20, 1'b1);
      check($sformatf("vec%0d_done", k), done_v, vecs[k].exp_done);
      check($sformatf("vec%0d_err", k), err_v, vecs[k].exp_err);
      check($sformatf("vec%0d_cfg", k), cfg_now(), vecs[k].exp_cfg);
      check($sformatf("vec%0d_busy", k), busy_v, 1'b1);
      tick();
      check($sformatf("vec%0d_done_clear", k), done_v, 1'b0);
      check($sformatf("vec%0d_busy_after", k), busy_v, vecs[k].exp_err);
      check($sformatf("vec%0d_err_hold", k), err_v, vecs[k].exp_err);
    end

    // Error state ignores stray valid bits and holds.
    send_frame(20'h00001, 1'b0, 1'b0, 20, 1'b1);
    check("err_enter", err_v, 1'b1);
    bit_valid_v = 1'b1;
    bit_v       = 1'b1;
    tick();
    tick();
    bit_valid_v = 1'b0;
    check("err_sticky", err_v, 1'b1);
    check("err_busy", busy_v, 1'b1);
    check("err_cfg_kept", cfg_now(), 20'hFFFFF);
    commit_ok("err_recover", 20'h0000F, 1'b0);

    // Readback of all ones: parity bit 0.
    commit_ok("all_ones", 20'hFFFFF, 1'b0);
    read_check(20'hFFFFF, 1'b0, 1'b0);

    // Restart after bit 7: only the second frame lands.
    send_frame(20'h00000, 1'b0, 1'b0, 8, 1'b0);
    check("restart_cfg_untouched", cfg_now(), 20'hFFFFF);
    commit_ok("restart", 20'hA5A5A, 1'b0);

    // Readback with ignored ld_start/bit_valid mid-stream, then odd weight.
    read_check(20'hA5A5A, 1'b0, 1'b1);
    commit_ok("odd_weight", 20'h4C005, 1'b1);
    read_check(20'h4C005, 1'b1, 1'b0);

    // rd_start during a write frame is ignored.
    ld_start_v = 1'b1;
    tick();
    ld_start_v = 1'b0;
    rd_start_v = 1'b1;
    tick();
    rd_start_v = 1'b0;
    check("rd_while_busy", tdo_valid_v, 1'b0);

    // Asynchronous reset after bit 10 of a frame.
    send_frame(20'h00000, 1'b0, 1'b0, 11, 1'b0);
    #2;
    rst_v = 1'b1;
    #1;
    check("arst_cfg", cfg_now(), 20'h0);
    check("arst_busy", busy_v, 1'b0);
    check("arst_err", err_v, 1'b0);
    check("arst_done", done_v, 1'b0);
    tick();
    rst_v = 1'b0;
    tick();
    commit_ok("post_reset", 20'h12345, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
